alu_adder_arbiter: RTL and testbench

//  Shares one N-bit ripple add/sub datapath between NREQ requesters.

---
 rtl/alu_pkg.sv | 16 +
 rtl/add_sub_core.sv | 29 ++
 rtl/alu_adder_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_adder_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the arbitrated add/sub datapath.
package alu_pkg;

    localparam int N_DEF    = 4;
    localparam int NREQ_DEF = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

    // Operation descriptor at the default operand width.
    typedef struct packed {
        logic [N_DEF-1:0] a;
        logic [N_DEF-1:0] b;
        logic             sub;
    } add_req_t;

endpackage

// File: rtl/add_sub_core.sv
// Combinational ripple-carry adder/subtractor; k=1 computes a-b.
module add_sub_core #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         k,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    logic [N:0]   c;
    logic [N-1:0] bx;

    assign c[0] = k;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign bx[gi]   = b[gi] ^ k;
            assign s[gi]    = a[gi] ^ bx[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & bx[gi]) | (c[gi] & (a[gi] ^ bx[gi]));
        end
    endgenerate

    assign cout = c[N];
    assign ovf  = c[N] ^ c[N-1];

endmodule

// File: rtl/alu_adder_arbiter.sv
// Round-robin arbiter sharing one add/sub core; one operation in flight,
// IDLE -> EXEC -> RESP with valid/ready on both sides.
module alu_adder_arbiter
    import alu_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0][N-1:0]  req_a,
    input  logic [NREQ-1:0][N-1:0]  req_b,
    input  logic [NREQ-1:0]         req_sub,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [N-1:0]            resp_sum,
    output logic                    resp_cout,
    output logic                    resp_ovf,
    output logic                    busy
);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
    } op_t;

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    op_t            op_q, op_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [IDW-1:0] gnt;
    logic [IDW-1:0] idx_w;
    int             idx;
    logic [N-1:0]   core_s;
    logic           core_cout;
    logic           core_ovf;

    add_sub_core #(.N(N)) u_core (
        .a    (op_q.a),
        .b    (op_q.b),
        .k    (op_q.sub),
        .s    (core_s),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    // Descending scan so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        gnt   = '0;
        idx   = 0;
        idx_w = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IDW'(idx);
            if (req_valid[idx_w]) gnt = idx_w;
        end
    end

    // Gated by rst_n so no handshake can be seen while reset is held.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state_q == IDLE) &&
                                   req_valid[gi] && (gnt == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        op_d     = op_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    op_d    = '{a: req_a[gnt], b: req_b[gnt], sub: req_sub[gnt]};
                    gnt_d   = gnt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d   = core_s;
                cout_d  = core_cout;
                ovf_d   = core_ovf;
                id_d    = gnt_q;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            op_q     <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            op_q     <= op_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
    assign resp_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Directed bench for alu_adder_arbiter at N=4, NREQ=2.
module tb_alu_adder_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][3:0] req_a;
    logic [1:0][3:0] req_b;
    logic [1:0]      req_sub;
    logic            resp_valid;
    logic            resp_ready;
    logic [0:0]      resp_id;
    logic [3:0]      resp_sum;
    logic            resp_cout;
    logic            resp_ovf;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_adder_arbiter #(.N(4), .NREQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
        chk({tag, "_busy"},       32'(busy),       0);
        chk({tag, "_req_ready"},  32'(req_ready),  0);
        chk({tag, "_sum"},        32'(resp_sum),   0);
        chk({tag, "_cout"},       32'(resp_cout),  0);
        chk({tag, "_ovf"},        32'(resp_ovf),   0);
        chk({tag, "_id"},         32'(resp_id),    0);
    endtask

    // One complete transaction on a single port with resp_ready asserted in RESP.
    task automatic run_op(input string tag, input int port, input logic [3:0] a,
                          input logic [3:0] b, input logic sub, input logic [3:0] es,
                          input logic ec, input logic eo);
        req_a[port]   = a;
        req_b[port]   = b;
        req_sub[port] = sub;
        req_valid     = 2'(1 << port);
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(1 << port));
        step();
        req_valid = 2'b00;
        chk({tag, "_exec_busy"},  32'(busy),       1);
        chk({tag, "_exec_valid"}, 32'(resp_valid), 0);
        chk({tag, "_exec_ready"}, 32'(req_ready),  0);
        step();
        chk({tag, "_resp_valid"}, 32'(resp_valid), 1);
        chk({tag, "_sum"},        32'(resp_sum),   32'(es));
        chk({tag, "_cout"},       32'(resp_cout),  32'(ec));
        chk({tag, "_ovf"},        32'(resp_ovf),   32'(eo));
        chk({tag, "_id"},         32'(resp_id),    32'(port));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(resp_valid), 0);
        chk({tag, "_done_busy"},  32'(busy),       0);
        $display("op %s port=%0d a=%b b=%b sub=%0d sum=%b cout=%0d ovf=%0d",
                 tag, port, a, b, sub, resp_sum, resp_cout, resp_ovf);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 2'b00;
        resp_ready = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_op("t1_add", 0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op("t2_sub", 1, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
        run_op("t3_sub", 0, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);

        // Fairness from reset: both ports continuously valid.
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        req_a[0]   = 4'd2;  req_b[0] = 4'd3;  req_sub[0] = 1'b0;
        req_a[1]   = 4'd1;  req_b[1] = 4'd2;  req_sub[1] = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        for (int op = 0; op < 4; op++) begin
            int g;
            g = op % 2;
            chk("t4_grant",   32'(req_ready), 32'(1 << g));
            chk("t4_onehot",  32'($countones(req_ready) <= 1), 1);
            step();
            chk("t4_exec_ready", 32'(req_ready), 0);
            step();
            chk("t4_resp_valid", 32'(resp_valid), 1);
            chk("t4_resp_id",    32'(resp_id),    32'(g));
            chk("t4_resp_sum",   32'(resp_sum),   (g == 0) ? 32'd5 : 32'd3);
            chk("t4_resp_ready", 32'(req_ready), 0);
            $display("op t4 n=%0d grant=%0d sum=%0d", op, resp_id, resp_sum);
            step();
        end
        req_valid  = 2'b00;
        resp_ready = 1'b0;

        // Back-pressure: response held for 5 cycles, operands mutated after accept.
        req_a[0]  = 4'b0110;
        req_b[0]  = 4'b0011;
        req_sub[0] = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("t5_grant", 32'(req_ready), 32'b01);
        step();
        req_a[0]  = 4'b0000;
        req_b[0]  = 4'b0000;
        req_sub[0] = 1'b1;
        req_valid = 2'b11;
        step();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) resp_ready = 1'b1;
            chk("t5_valid", 32'(resp_valid), 1);
            chk("t5_sum",   32'(resp_sum),   32'b1001);
            chk("t5_cout",  32'(resp_cout),  0);
            chk("t5_ovf",   32'(resp_ovf),   1);
            chk("t5_id",    32'(resp_id),    0);
            chk("t5_ready", 32'(req_ready),  0);
            chk("t5_busy",  32'(busy),       1);
            $display("op t5 hold=%0d sum=%b resp_ready=%0d", i, resp_sum, resp_ready);
            step();
        end

        // Reset during EXEC drops the in-flight op and restores rr_ptr to 0.
        chk("t6_grant_before", 32'(req_ready), 32'b10);
        resp_ready = 1'b0;
        step();
        chk("t6_exec_busy", 32'(busy), 1);
        rst_n = 1'b0;
        step();
        chk_all_zero("t6_reset");
        rst_n = 1'b1;
        #1;
        chk("t6_grant_after", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        step();
        step();
        chk("t6_no_resp", 32'(resp_valid), 0);
        chk("t6_idle",    32'(busy),       0);
        $display("op t6 reset-in-exec dropped");

        run_op("t6_post", 0, 4'b0101, 4'b0010, 1'b1, 4'b0011, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
